// File: rtl/mult_share_arb_pkg.sv
// Shared definitions for the two-requester arbiter in front of the booth multiplier.
package mult_share_arb_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StSetup = 2'd1,
    StRun   = 2'd2,
    StResp  = 2'd3
  } state_e;

  localparam int unsigned SETUP_CYCLES_DEF = 2;
  localparam int unsigned TIMEOUT_DEF      = 63;
  localparam int unsigned CntW             = 8;

endpackage

// File: rtl/rr_pick2.sv
// Two-way round-robin pick: a lone request wins, a tie goes to the one not served last.
module rr_pick2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] pick
);

  always_comb begin
    pick = 2'b00;
    unique case (req)
      2'b01:   pick = 2'b01;
      2'b10:   pick = 2'b10;
      2'b11:   pick = last ? 2'b01 : 2'b10;
      default: pick = 2'b00;
    endcase
  end

endmodule

// File: rtl/mult_share_arb.sv
// Shares one booth multiplier between two requesters: grant, setup, run with timeout,
// one-cycle response.
module mult_share_arb
  import mult_share_arb_pkg::*;
#(
  parameter int unsigned SETUP_CYCLES = SETUP_CYCLES_DEF,
  parameter int unsigned TIMEOUT      = TIMEOUT_DEF
) (
  input  logic        clk,
  input  logic        clr,
  input  logic [1:0]  req,
  input  logic [7:0]  mplier0,
  input  logic [7:0]  mcand0,
  input  logic [7:0]  mplier1,
  input  logic [7:0]  mcand1,
  output logic [1:0]  gnt,
  output logic [1:0]  done,
  output logic [15:0] result,
  output logic        err,
  output logic        m_go,
  output logic [7:0]  m_multiplier,
  output logic [7:0]  m_multiplicand,
  input  logic        m_over,
  input  logic [15:0] m_product
);

  state_e          st_q, st_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [1:0]      gnt_q, gnt_d;
  logic            last_q, last_d;
  logic [15:0]     result_q, result_d;
  logic            to_q, to_d;
  logic [7:0]      mplier_q, mplier_d;
  logic [7:0]      mcand_q, mcand_d;
  logic [1:0]      pick;

  rr_pick2 u_pick (
    .req  (req),
    .last (last_q),
    .pick (pick)
  );

  always_comb begin
    st_d     = st_q;
    cnt_d    = cnt_q;
    gnt_d    = gnt_q;
    last_d   = last_q;
    result_d = result_q;
    to_d     = to_q;
    mplier_d = mplier_q;
    mcand_d  = mcand_q;
    unique case (st_q)
      StIdle: begin
        if (|req) begin
          gnt_d    = pick;
          mplier_d = pick[1] ? mplier1 : mplier0;
          mcand_d  = pick[1] ? mcand1 : mcand0;
          cnt_d    = '0;
          st_d     = StSetup;
        end
      end
      StSetup: begin
        if (cnt_q == CntW'(SETUP_CYCLES - 1)) begin
          cnt_d = '0;
          st_d  = StRun;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StRun: begin
        if (m_over) begin
          result_d = m_product;
          to_d     = 1'b0;
          st_d     = StResp;
        end else if (cnt_q == CntW'(TIMEOUT - 1)) begin
          // Counter reaches TIMEOUT at this edge: abort with a zero result.
          result_d = '0;
          to_d     = 1'b1;
          st_d     = StResp;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StResp: begin
        gnt_d  = 2'b00;
        last_d = gnt_q[1];
        cnt_d  = '0;
        st_d   = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      st_q     <= StIdle;
      cnt_q    <= '0;
      gnt_q    <= 2'b00;
      last_q   <= 1'b1;
      result_q <= '0;
      to_q     <= 1'b0;
      mplier_q <= '0;
      mcand_q  <= '0;
    end else begin
      st_q     <= st_d;
      cnt_q    <= cnt_d;
      gnt_q    <= gnt_d;
      last_q   <= last_d;
      result_q <= result_d;
      to_q     <= to_d;
      mplier_q <= mplier_d;
      mcand_q  <= mcand_d;
    end
  end

  assign gnt            = gnt_q;
  assign done           = (st_q == StResp) ? gnt_q : 2'b00;
  assign err            = (st_q == StResp) && to_q;
  assign result         = result_q;
  assign m_go           = (st_q == StRun);
  assign m_multiplier   = mplier_q;
  assign m_multiplicand = mcand_q;

endmodule

// File: tb/tb_mult_share_arb.sv
// Directed bench for mult_share_arb with a behavioural booth multiplier stand-in.
module tb_mult_share_arb;

  localparam int unsigned SETUP = 2;
  localparam int unsigned TOUT  = 63;
  localparam int unsigned MUL_LAT = 4;  // multiplier raises m_over in its 4th go cycle

  logic        clk = 1'b0;
  logic        clr;
  logic [1:0]  req;
  logic [7:0]  mplier0, mcand0, mplier1, mcand1;
  logic [1:0]  gnt, done;
  logic [15:0] result;
  logic        err, m_go;
  logic [7:0]  m_multiplier, m_multiplicand;
  logic        m_over;
  logic [15:0] m_product;

  logic        mul_en;
  logic [7:0]  mcnt;
  logic signed [15:0] prod;

  int n_total = 0;
  int n_bad   = 0;

  always #5 clk = ~clk;

  mult_share_arb #(
    .SETUP_CYCLES (SETUP),
    .TIMEOUT      (TOUT)
  ) dut (
    .clk            (clk),
    .clr            (clr),
    .req            (req),
    .mplier0        (mplier0),
    .mcand0         (mcand0),
    .mplier1        (mplier1),
    .mcand1         (mcand1),
    .gnt            (gnt),
    .done           (done),
    .result         (result),
    .err            (err),
    .m_go           (m_go),
    .m_multiplier   (m_multiplier),
    .m_multiplicand (m_multiplicand),
    .m_over         (m_over),
    .m_product      (m_product)
  );

  // Multiplier stand-in sharing clk/clr with the arbiter.
  assign prod      = $signed(m_multiplier) * $signed(m_multiplicand);
  assign m_product = m_over ? prod : 16'h0000;

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      mcnt   <= '0;
      m_over <= 1'b0;
    end else begin
      mcnt   <= m_go ? mcnt + 8'd1 : 8'd0;
      m_over <= mul_en && m_go && (mcnt == 8'(MUL_LAT - 2)) && !m_over;
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Waits (bounded) for a done pulse and checks which requester it went to.
  task automatic wait_done(input string tag, input logic [1:0] exp_done, output int cyc);
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (done == 2'b00 && cyc < 300);
    check_eq(tag, {30'b0, done}, {30'b0, exp_done});
  endtask

  task automatic wait_go(input string tag);
    int n;
    n = 0;
    while (!m_go && n < 40) begin
      @(negedge clk);
      n++;
    end
    check_eq(tag, {31'b0, m_go}, 32'd1);
  endtask

  initial begin
    int cyc;
    clr = 1'b0; req = 2'b00; mul_en = 1'b1;
    mplier0 = '0; mcand0 = '0; mplier1 = '0; mcand1 = '0;
    #1;
    check_eq("rst_gnt", {30'b0, gnt}, 32'd0);
    check_eq("rst_done", {30'b0, done}, 32'd0);
    check_eq("rst_err", {31'b0, err}, 32'd0);
    check_eq("rst_result", {16'b0, result}, 32'd0);
    check_eq("rst_go", {31'b0, m_go}, 32'd0);
    check_eq("rst_mplier", {24'b0, m_multiplier}, 32'd0);
    @(negedge clk);
    clr = 1'b1;

    // Simultaneous requests: 0 wins first after reset, then 1.
    @(negedge clk);
    mplier0 = 8'hFF; mcand0 = 8'hFF; mplier1 = 8'd7; mcand1 = 8'hFE;
    req = 2'b11;
    wait_done("t2_done0", 2'b01, cyc);
    check_eq("t2_res0", {16'b0, result}, 32'h0001);
    check_eq("t2_err0", {31'b0, err}, 32'd0);
    req = 2'b10;
    @(negedge clk);
    check_eq("t2_idle_gnt", {30'b0, gnt}, 32'd0);
    wait_done("t2_done1", 2'b10, cyc);
    check_eq("t2_res1", {16'b0, result}, 32'hFFF2);
    req = 2'b00;

    // Lone request; req and operands change after grant without effect.
    @(negedge clk);
    mplier0 = 8'd3; mcand0 = 8'd5; req = 2'b01;
    @(negedge clk);
    check_eq("t1_gnt", {30'b0, gnt}, 32'h1);
    check_eq("t1_mplier", {24'b0, m_multiplier}, 32'd3);
    req = 2'b00; mplier0 = 8'd100; mcand0 = 8'd0;
    wait_done("t1_done", 2'b01, cyc);
    // Cycles after the sampling edge: setup, run, then the response cycle.
    check_eq("t1_latency", 32'(cyc + 1), 32'(SETUP + MUL_LAT + 1));
    check_eq("t1_res", {16'b0, result}, 32'd15);
    check_eq("t1_err", {31'b0, err}, 32'd0);
    check_eq("t1_gnt_at_done", {30'b0, gnt}, 32'h1);
    @(negedge clk);
    check_eq("t1_done_once", {30'b0, done}, 32'd0);
    check_eq("t1_gnt_clr", {30'b0, gnt}, 32'd0);

    // Requester 0 back-to-back three times.
    mplier0 = 8'hFC; mcand0 = 8'd6; req = 2'b01;
    for (int i = 0; i < 3; i++) begin
      wait_done($sformatf("t3_done%0d", i), 2'b01, cyc);
      check_eq($sformatf("t3_res%0d", i), {16'b0, result}, 32'hFFE8);
      if (i == 2) req = 2'b00;
      @(negedge clk);
      check_eq($sformatf("t3_idle%0d", i), {30'b0, gnt}, 32'd0);
    end

    // Reset mid-run, then the held request is served normally.
    mplier0 = 8'd9; mcand0 = 8'hFD; req = 2'b01;
    wait_go("t5_go");
    #1 clr = 1'b0;
    #1;
    check_eq("t5_gnt", {30'b0, gnt}, 32'd0);
    check_eq("t5_go_rst", {31'b0, m_go}, 32'd0);
    check_eq("t5_result", {16'b0, result}, 32'd0);
    check_eq("t5_mplier", {24'b0, m_multiplier}, 32'd0);
    check_eq("t5_mcand", {24'b0, m_multiplicand}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_eq("t5_no_done", {30'b0, done}, 32'd0);
    end
    clr = 1'b1;
    wait_done("t5_done", 2'b01, cyc);
    check_eq("t5_latency", 32'(cyc), 32'(SETUP + MUL_LAT + 1));
    check_eq("t5_res", {16'b0, result}, 32'hFFE5);
    req = 2'b00;

    // Timeout: multiplier never completes.
    @(negedge clk);
    mul_en = 1'b0; mplier0 = 8'd2; mcand0 = 8'd2; req = 2'b01;
    wait_go("t4_go");
    wait_done("t4_done", 2'b01, cyc);
    check_eq("t4_cycles", 32'(cyc), 32'(TOUT));
    check_eq("t4_err", {31'b0, err}, 32'd1);
    check_eq("t4_res", {16'b0, result}, 32'd0);
    req = 2'b00;
    @(negedge clk);
    check_eq("t4_err_pulse", {31'b0, err}, 32'd0);
    mul_en = 1'b1;

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
